// File: rtl/mux_sel_scanner_pkg.sv
// mux_sel_scanner_pkg: channel count and select width shared with the downstream 4:1 mux and its bench
package mux_sel_scanner_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W = 2;
endpackage

// File: rtl/mux_sel_scanner_rr_next_sel.sv
// rr_next_sel: rotating-priority search for the next enabled channel after cur
//   cur   - current select
//   mask  - channel enable mask, bit k = channel k may be selected
//   nxt   - first enabled channel at cur+1, cur+2, cur+3 (mod 4); cur when none
//   valid - a different enabled channel exists
module rr_next_sel
  import mux_sel_scanner_pkg::*;
(
  input  logic [SEL_W-1:0]  cur,
  input  logic [NUM_CH-1:0] mask,
  output logic [SEL_W-1:0]  nxt,
  output logic              valid
);
  // Walk the offsets farthest-first so the nearest enabled channel wins.
  always_comb begin
    nxt = cur;
    valid = 1'b0;
    for (int d = NUM_CH - 1; d >= 1; d--) begin
      if (mask[cur + SEL_W'(d)]) begin
        nxt = cur + SEL_W'(d);
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mux_sel_scanner.sv
// mux_sel_scanner: registered select sequencer for a 4:1 mux with prescaled or single-step advance
//   i_clk   - clock, rising edge
//   i_rst_n - async active-low reset
//   i_en    - 1 = step every DIV cycles, 0 = manual stepping via i_step
//   i_mask  - channel enable mask, sampled only at an advance
//   i_step  - manual step level, rising edge honoured while i_en = 0
//   o_s     - select to the mux
//   o_tick  - high in the cycle after o_s changes
//   o_wrap  - high with o_tick when the new index is below the old one
module mux_sel_scanner
  import mux_sel_scanner_pkg::*;
#(
  parameter int DIV = 100
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic [NUM_CH-1:0] i_mask,
  input  logic              i_step,
  output logic [SEL_W-1:0]  o_s,
  output logic              o_tick,
  output logic              o_wrap
);
  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);
  logic [PW-1:0] cnt;
  logic step_d;
  logic [SEL_W-1:0] nxt;
  logic valid;
  logic adv;
  logic move;
  rr_next_sel u_next (
    .cur  (o_s),
    .mask (i_mask),
    .nxt  (nxt),
    .valid(valid)
  );
  assign adv = i_en ? (cnt == LAST) : (i_step & ~step_d);
  assign move = adv & valid;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
      step_d <= 1'b0;
      o_s <= '0;
      o_tick <= 1'b0;
      o_wrap <= 1'b0;
    end else begin
      cnt <= (i_en && cnt != LAST) ? cnt + 1'b1 : '0;
      step_d <= i_step;
      o_tick <= move;
      o_wrap <= move & (nxt < o_s);
      if (move) o_s <= nxt;
    end
  end
endmodule

// File: tb/tb_mux_sel_scanner.sv
// tb_mux_sel_scanner: directed and random stimulus checked against a cycle-level reference model
module tb_mux_sel_scanner;
  localparam int DIV = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic [3:0] mask = 4'hf;
  logic step = 1'b0;
  logic [1:0] s;
  logic tick, wrap;
  logic [3:0] w [4];
  logic [3:0] f;
  int checks = 0;
  int failures = 0;
  int m_s, m_run, m_prev, m_tick, m_wrap;

  mux_sel_scanner #(.DIV(DIV)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_en   (en),
    .i_mask (mask),
    .i_step (step),
    .o_s    (s),
    .o_tick (tick),
    .o_wrap (wrap)
  );

  assign f = w[s];

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s = 0;
    m_run = 0;
    m_prev = 0;
    m_tick = 0;
    m_wrap = 0;
  endtask

  task automatic cycle();
    int adv, found, nx;
    @(posedge clk);
    adv = 0;
    if (en) begin
      m_run++;
      if (m_run == DIV) begin
        adv = 1;
        m_run = 0;
      end
    end else begin
      m_run = 0;
      adv = (step && !m_prev) ? 1 : 0;
    end
    m_prev = step;
    m_tick = 0;
    m_wrap = 0;
    if (adv) begin
      found = 0;
      nx = m_s;
      for (int d = 1; d < 4; d++)
        if (!found && mask[(m_s + d) % 4]) begin
          found = 1;
          nx = (m_s + d) % 4;
        end
      if (found) begin
        m_tick = 1;
        m_wrap = (nx < m_s) ? 1 : 0;
        m_s = nx;
      end
    end
    #1;
    chk("o_s", int'(s), m_s);
    chk("o_tick", int'(tick), m_tick);
    chk("o_wrap", int'(wrap), m_wrap);
    chk("mux_f", int'(f), 1 << m_s);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    for (int k = 0; k < 4; k++) w[k] = 4'(1 << k);
    model_reset();
    #2;
    chk("rst_o_s", int'(s), 0);
    chk("rst_o_tick", int'(tick), 0);
    chk("rst_o_wrap", int'(wrap), 0);
    #10;
    rst_n = 1'b1;
    en = 1'b1;
    mask = 4'b1111;
    run(22);
    mask = 4'b1010;
    run(24);
    mask = 4'b0000;
    run(20);
    mask = 4'b0100;
    run(16);
    en = 1'b0;
    mask = 4'b1111;
    step = 1'b1;
    run(10);
    step = 1'b0;
    run(2);
    en = 1'b1;
    step = 1'b1;
    run(3);
    step = 1'b0;
    run(9);
    en = 1'b0;
    while (m_s != 2) begin
      step = 1'b1;
      run(1);
      step = 1'b0;
      run(1);
    end
    en = 1'b1;
    run(2);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_o_s", int'(s), 0);
    chk("async_rst_o_tick", int'(tick), 0);
    #10;
    rst_n = 1'b1;
    run(10);
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) mask = 4'($urandom);
      step = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 150) == 0) begin
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rand_rst_o_s", int'(s), 0);
        #2;
        rst_n = 1'b1;
      end
      cycle();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
